cmd_frame_parser: RTL and testbench
===================================

# cmd_frame_parser

Byte-level receiver for the USB-CDC command protocol. Sits between the USB-CDC receive byte stream and the command handlers (I2C, UART, PWM, DAC). It locates frames, validates header, length and checksum, and presents the command code, length and payload stream to the handlers. It signals commit or abort per frame.

## Interface
Parameters:
- `MAX_LEN`, 256: largest accepted payload length in bytes. A frame whose length exceeds it is rejected.
- `TIMEOUT_CYCLES`, 50_000: idle clocks allowed between bytes of one frame (1 ms at 50 MHz).

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  asynchronous, active-high reset
- `usb_data_in`  in  8  received byte
- `usb_data_valid_in`  in  1  one-cycle strobe, byte valid. No backpressure.
- `cmd_type`  out  8  command code of the current frame
- `cmd_length`  out  16  payload length of the current frame
- `cmd_start`  out  1  one-cycle pulse: header and length accepted
- `payload_data`  out  8  payload byte
- `payload_valid`  out  1  one-cycle strobe per payload byte
- `payload_index`  out  16  index of `payload_data`, counting from 0
- `cmd_done`  out  1  one-cycle pulse: checksum correct, frame committed
- `cmd_error`  out  1  one-cycle pulse: frame aborted
- `err_code`  out  2  reason for the abort, valid with `cmd_error`. 01 = checksum, 10 = length, 11 = timeout.

## Operation
Frame format: `0xAA 0x55 CMD LEN_H LEN_L PAYLOAD[LEN] CHK`.
- CHK is the 8-bit sum, modulo 256, of CMD, LEN_H, LEN_L and every payload byte.

States advance only on cycles where `usb_data_valid_in` is high:
- IDLE: a 0xAA byte moves to HDR2. Any other byte stays in IDLE.
- HDR2: 0x55 moves to CMD. 0xAA stays in HDR2 (resync). Any other byte returns to IDLE.
- CMD: latch the byte into an internal cmd register and start the checksum at that byte. Move to LEN_H.
- LEN_H: latch the high length byte and add it to the checksum. Move to LEN_L.
- LEN_L: form the 16-bit length and add the byte to the checksum.
  - If length > MAX_LEN: pulse `cmd_error` with code 10 and return to IDLE. `cmd_start` is not pulsed.
  - Otherwise: copy cmd and length to `cmd_type`/`cmd_length` and pulse `cmd_start`. Go to PAYLOAD if length > 0, else go to CHK.
- PAYLOAD: output each byte with `payload_valid` and the current `payload_index`, and add it to the checksum. After byte number length−1, move to CHK.
- CHK: if the byte equals the running sum, pulse `cmd_done`. Otherwise pulse `cmd_error` with code 01. Return to IDLE in both cases.

Timeout:
- A counter clears on every valid byte and counts while the state is not IDLE.
- On reaching TIMEOUT_CYCLES: pulse `cmd_error` with code 11 and return to IDLE.
- If a timeout and a valid byte fall on the same cycle, the byte wins: it is processed and the counter clears.

Handler contract:
- Handlers may act on payload bytes as they arrive.
- They must discard side effects if `cmd_error` follows `cmd_start`.
- `cmd_done` and `cmd_error` are mutually exclusive. Exactly one of them follows every `cmd_start`.

Reset:
- Asserting `rst` at any time, including mid-frame, forces IDLE. No done or error pulse is generated.
- All outputs reset to 0; `err_code` resets to 00.

## Timing
- Every output is registered and appears one cycle after the `usb_data_valid_in` cycle that causes it:
  - `cmd_start` one cycle after LEN_L.
  - `payload_valid` one cycle after each payload byte.
  - `cmd_done` or `cmd_error` one cycle after CHK.
- Error code 10 is pulsed one cycle after LEN_L. A timeout pulse is issued on the cycle after the counter hits TIMEOUT_CYCLES.
- `cmd_type` and `cmd_length` stay stable from `cmd_start` until the next `cmd_start`.
- `payload_data` and `payload_index` hold their last value between strobes.
- Back-to-back valid bytes on consecutive clocks are supported. A new 0xAA may arrive on the cycle immediately after CHK.
- Maximum throughput is one byte per clock. No input is ever dropped.
- Length counter and index are 16 bits wide. The checksum is 8 bits and wraps.

## Test plan
- Heartbeat `AA 55 FF 00 00 FF` → `cmd_start` with `cmd_type`=0xFF and `cmd_length`=0. No `payload_valid`. `cmd_done` one cycle after the last byte.
- I2C write `AA 55 05 00 04 50 AA 12 34 49` → `cmd_start` with type 0x05 and length 4. Payload 50, AA, 12, 34 on indices 0–3, then `cmd_done`.
- I2C read `AA 55 06 00 03 50 BB 04 18`, sent with 3-cycle gaps between bytes → payload 50, BB, 04, then `cmd_done`. Then the same frame with CHK=0x19 → `cmd_error` with `err_code`=01 and no `cmd_done`.
- Resync with `AA AA 55 FF 00 00 FF`, preceded by garbage `12 AA 34` → exactly one heartbeat `cmd_done` and no errors.
- Length 0x0101 with MAX_LEN=256 → `cmd_error` with code 10 after LEN_L and no `cmd_start`. A following valid heartbeat is accepted.
- Timeout: stop after `AA 55 05 00 04 50` for TIMEOUT_CYCLES clocks → `cmd_error` with code 11 and return to IDLE. Separately, assert `rst` mid-payload → all outputs 0 and the next frame parses correctly.

Source files
------------

// File: rtl/cmd_frame_parser.sv
// ---------------------------------------------------------------------------
// cmd_frame_parser
//   Byte-level receiver for the USB-CDC command protocol. Finds frames of the
//   form AA 55 CMD LEN_H LEN_L PAYLOAD[LEN] CHK, validates length and
//   checksum, and streams the command and payload to the handlers.
//
// Ports:
//   clk, rst             system clock, async active-high reset
//   usb_data_in[7:0]     received byte
//   usb_data_valid_in    byte strobe (no backpressure)
//   cmd_type[7:0]        command code, updated with cmd_start
//   cmd_length[15:0]     payload length, updated with cmd_start
//   cmd_start            pulse: header and length accepted
//   payload_data[7:0]    payload byte
//   payload_valid        pulse per payload byte
//   payload_index[15:0]  index of payload_data
//   cmd_done             pulse: checksum good, frame committed
//   cmd_error            pulse: frame aborted
//   err_code[1:0]        abort reason: 01 checksum, 10 length, 11 timeout
// All outputs are registered, one cycle after the causing byte.
// ---------------------------------------------------------------------------
module cmd_frame_parser #(
    parameter int MAX_LEN        = 256,
    parameter int TIMEOUT_CYCLES = 50_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  usb_data_in,
    input  logic        usb_data_valid_in,
    output logic [7:0]  cmd_type,
    output logic [15:0] cmd_length,
    output logic        cmd_start,
    output logic [7:0]  payload_data,
    output logic        payload_valid,
    output logic [15:0] payload_index,
    output logic        cmd_done,
    output logic        cmd_error,
    output logic [1:0]  err_code
);

    localparam int          TW      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYCLES);
    localparam logic [15:0] MAX_LEN_W = 16'(MAX_LEN);

    typedef enum logic [2:0] {
        S_IDLE, S_HDR2, S_CMD, S_LEN_H, S_LEN_L, S_PAYLOAD, S_CHK
    } state_t;

    state_t        state, state_n;
    logic [7:0]    cmd_reg;
    logic [7:0]    len_h;
    logic [15:0]   len_reg;
    logic [15:0]   pay_cnt;
    logic [7:0]    chk;
    logic [TW-1:0] tmo_cnt;

    logic [15:0]   len_word;
    logic          timeout;
    logic          start_n, done_n, err_n, pay_vld_n;
    logic [1:0]    err_code_n;

    assign len_word = {len_h, usb_data_in};
    // A byte arriving on the same cycle as the timeout takes priority.
    assign timeout  = (state != S_IDLE) && !usb_data_valid_in && (tmo_cnt == TMO_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n    = state;
        start_n    = 1'b0;
        done_n     = 1'b0;
        err_n      = 1'b0;
        pay_vld_n  = 1'b0;
        err_code_n = err_code;
        if (usb_data_valid_in) begin
            case (state)
                S_IDLE:  if (usb_data_in == 8'hAA) state_n = S_HDR2;
                S_HDR2: begin
                    if (usb_data_in == 8'h55)      state_n = S_CMD;
                    else if (usb_data_in != 8'hAA) state_n = S_IDLE;
                end
                S_CMD:   state_n = S_LEN_H;
                S_LEN_H: state_n = S_LEN_L;
                S_LEN_L: begin
                    if (len_word > MAX_LEN_W) begin
                        err_n      = 1'b1;
                        err_code_n = 2'b10;
                        state_n    = S_IDLE;
                    end else begin
                        start_n = 1'b1;
                        state_n = (len_word == 16'd0) ? S_CHK : S_PAYLOAD;
                    end
                end
                S_PAYLOAD: begin
                    pay_vld_n = 1'b1;
                    if (pay_cnt == len_reg - 16'd1) state_n = S_CHK;
                end
                S_CHK: begin
                    if (usb_data_in == chk) begin
                        done_n = 1'b1;
                    end else begin
                        err_n      = 1'b1;
                        err_code_n = 2'b01;
                    end
                    state_n = S_IDLE;
                end
                default: state_n = S_IDLE;
            endcase
        end else if (timeout) begin
            err_n      = 1'b1;
            err_code_n = 2'b11;
            state_n    = S_IDLE;
        end
    end

    // Frame datapath: running checksum, length and payload position.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_reg <= '0;
            len_h   <= '0;
            len_reg <= '0;
            pay_cnt <= '0;
            chk     <= '0;
        end else if (usb_data_valid_in) begin
            case (state)
                S_CMD: begin
                    cmd_reg <= usb_data_in;
                    chk     <= usb_data_in;
                end
                S_LEN_H: begin
                    len_h <= usb_data_in;
                    chk   <= chk + usb_data_in;
                end
                S_LEN_L: begin
                    len_reg <= len_word;
                    pay_cnt <= '0;
                    chk     <= chk + usb_data_in;
                end
                S_PAYLOAD: begin
                    pay_cnt <= pay_cnt + 16'd1;
                    chk     <= chk + usb_data_in;
                end
                default: ;
            endcase
        end
    end

    // Inter-byte idle counter; saturates so it cannot wrap past the limit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                       tmo_cnt <= '0;
        else if (usb_data_valid_in || state == S_IDLE) tmo_cnt <= '0;
        else if (tmo_cnt != TMO_MAX)                   tmo_cnt <= tmo_cnt + 1'b1;
    end

    // Registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_type      <= '0;
            cmd_length    <= '0;
            cmd_start     <= 1'b0;
            payload_data  <= '0;
            payload_valid <= 1'b0;
            payload_index <= '0;
            cmd_done      <= 1'b0;
            cmd_error     <= 1'b0;
            err_code      <= 2'b00;
        end else begin
            cmd_start     <= start_n;
            payload_valid <= pay_vld_n;
            cmd_done      <= done_n;
            cmd_error     <= err_n;
            err_code      <= err_code_n;
            if (start_n) begin
                cmd_type   <= cmd_reg;
                cmd_length <= len_word;
            end
            if (pay_vld_n) begin
                payload_data  <= usb_data_in;
                payload_index <= pay_cnt;
            end
        end
    end

endmodule

// File: tb/tb_cmd_frame_parser.sv
module tb_cmd_frame_parser;

    localparam int TMO = 20;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  usb_data_in = '0;
    logic        usb_data_valid_in = 1'b0;
    logic [7:0]  cmd_type;
    logic [15:0] cmd_length;
    logic        cmd_start;
    logic [7:0]  payload_data;
    logic        payload_valid;
    logic [15:0] payload_index;
    logic        cmd_done;
    logic        cmd_error;
    logic [1:0]  err_code;

    int checks = 0;
    int errors = 0;

    // pulse counters and payload log, sampled on the falling edge
    int n_start = 0, n_done = 0, n_err = 0;
    logic [7:0]  pay_q[$];
    logic [15:0] idx_q[$];

    cmd_frame_parser #(.MAX_LEN(256), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst),
        .usb_data_in(usb_data_in), .usb_data_valid_in(usb_data_valid_in),
        .cmd_type(cmd_type), .cmd_length(cmd_length), .cmd_start(cmd_start),
        .payload_data(payload_data), .payload_valid(payload_valid),
        .payload_index(payload_index), .cmd_done(cmd_done),
        .cmd_error(cmd_error), .err_code(err_code)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (cmd_start) n_start++;
        if (cmd_done)  n_done++;
        if (cmd_error) n_err++;
        if (payload_valid) begin
            pay_q.push_back(payload_data);
            idx_q.push_back(payload_index);
        end
    end

    // Drive one byte; returns 1 time unit after the edge that takes it.
    task automatic send(input logic [7:0] b);
        usb_data_in       = b;
        usb_data_valid_in = 1'b1;
        @(posedge clk);
        #1;
        usb_data_valid_in = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        idle(2);
        checks++;
        if ({cmd_type, cmd_length, cmd_start, payload_data, payload_valid,
             payload_index, cmd_done, cmd_error, err_code} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got %h %h %b %h %b %h %b %b %b exp all zero",
                     cmd_type, cmd_length, cmd_start, payload_data, payload_valid,
                     payload_index, cmd_done, cmd_error, err_code);
        end
        rst = 1'b0;
        idle(2);
    endtask

    task automatic test_heartbeat;
        int s0, p0, e0;
        s0 = n_start; p0 = pay_q.size(); e0 = n_err;
        send(8'hAA); send(8'h55); send(8'hFF); send(8'h00); send(8'h00);
        checks++;
        if (cmd_start !== 1'b1 || cmd_type !== 8'hFF || cmd_length !== 16'd0) begin
            errors++;
            $display("FAIL hb_start got start=%b type=%h len=%h exp 1 ff 0000",
                     cmd_start, cmd_type, cmd_length);
        end
        send(8'hFF);
        checks++;
        if (cmd_done !== 1'b1 || cmd_error !== 1'b0) begin
            errors++;
            $display("FAIL hb_done got done=%b err=%b exp 1 0", cmd_done, cmd_error);
        end
        idle(2);
        checks++;
        if (pay_q.size() != p0 || n_start - s0 != 1 || n_err != e0) begin
            errors++;
            $display("FAIL hb_counts got pay=%0d start=%0d err=%0d exp 0 1 0",
                     pay_q.size() - p0, n_start - s0, n_err - e0);
        end
    endtask

    task automatic test_i2c_write;
        logic [7:0] exp_p[4];
        int p0;
        exp_p = '{8'h50, 8'hAA, 8'h12, 8'h34};
        p0 = pay_q.size();
        send(8'hAA); send(8'h55); send(8'h05); send(8'h00); send(8'h04);
        checks++;
        if (cmd_start !== 1'b1 || cmd_type !== 8'h05 || cmd_length !== 16'd4) begin
            errors++;
            $display("FAIL wr_start got start=%b type=%h len=%h exp 1 05 0004",
                     cmd_start, cmd_type, cmd_length);
        end
        for (int i = 0; i < 4; i++) begin
            send(exp_p[i]);
            checks++;
            if (payload_valid !== 1'b1 || payload_data !== exp_p[i] ||
                payload_index !== 16'(i)) begin
                errors++;
                $display("FAIL wr_payload%0d got v=%b d=%h i=%h exp 1 %h %h",
                         i, payload_valid, payload_data, payload_index, exp_p[i], 16'(i));
            end
        end
        send(8'h49);
        checks++;
        if (cmd_done !== 1'b1 || cmd_error !== 1'b0 || payload_valid !== 1'b0) begin
            errors++;
            $display("FAIL wr_done got done=%b err=%b pv=%b exp 1 0 0",
                     cmd_done, cmd_error, payload_valid);
        end
        checks++;
        if (payload_data !== 8'h34 || payload_index !== 16'd3) begin
            errors++;
            $display("FAIL wr_hold got d=%h i=%h exp 34 0003", payload_data, payload_index);
        end
        idle(1);
        checks++;
        if (pay_q.size() - p0 != 4) begin
            errors++;
            $display("FAIL wr_count got %0d exp 4", pay_q.size() - p0);
        end
    endtask

    task automatic test_gaps;
        logic [7:0] fr[9];
        int p0, d0, e0;
        fr = '{8'hAA, 8'h55, 8'h06, 8'h00, 8'h03, 8'h50, 8'hBB, 8'h04, 8'h18};
        p0 = pay_q.size(); d0 = n_done;
        for (int i = 0; i < 9; i++) begin send(fr[i]); idle(3); end
        checks++;
        if (pay_q.size() - p0 != 3 || n_done - d0 != 1) begin
            errors++;
            $display("FAIL rd_counts got pay=%0d done=%0d exp 3 1", pay_q.size() - p0, n_done - d0);
        end else begin
            checks++;
            if (pay_q[p0] !== 8'h50 || pay_q[p0+1] !== 8'hBB || pay_q[p0+2] !== 8'h04 ||
                idx_q[p0+2] !== 16'd2) begin
                errors++;
                $display("FAIL rd_payload got %h %h %h idx2=%h exp 50 bb 04 0002",
                         pay_q[p0], pay_q[p0+1], pay_q[p0+2], idx_q[p0+2]);
            end
        end
        // same frame, wrong checksum
        d0 = n_done; e0 = n_err;
        fr[8] = 8'h19;
        for (int i = 0; i < 8; i++) begin send(fr[i]); idle(3); end
        send(fr[8]);
        checks++;
        if (cmd_error !== 1'b1 || err_code !== 2'b01 || cmd_done !== 1'b0) begin
            errors++;
            $display("FAIL rd_badchk got err=%b code=%b done=%b exp 1 01 0",
                     cmd_error, err_code, cmd_done);
        end
        idle(2);
        checks++;
        if (n_done != d0 || n_err - e0 != 1) begin
            errors++;
            $display("FAIL rd_badchk_counts got done=%0d err=%0d exp 0 1", n_done - d0, n_err - e0);
        end
    endtask

    task automatic test_resync;
        logic [7:0] fr[10];
        int d0, e0, s0;
        fr = '{8'h12, 8'hAA, 8'h34, 8'hAA, 8'hAA, 8'h55, 8'hFF, 8'h00, 8'h00, 8'hFF};
        d0 = n_done; e0 = n_err; s0 = n_start;
        for (int i = 0; i < 10; i++) send(fr[i]);
        idle(2);
        checks++;
        if (n_done - d0 != 1 || n_err != e0 || n_start - s0 != 1) begin
            errors++;
            $display("FAIL resync got done=%0d err=%0d start=%0d exp 1 0 1",
                     n_done - d0, n_err - e0, n_start - s0);
        end
    endtask

    task automatic test_len_err;
        int s0, d0;
        s0 = n_start;
        send(8'hAA); send(8'h55); send(8'h07); send(8'h01); send(8'h01);
        checks++;
        if (cmd_error !== 1'b1 || err_code !== 2'b10 || cmd_start !== 1'b0) begin
            errors++;
            $display("FAIL len_err got err=%b code=%b start=%b exp 1 10 0",
                     cmd_error, err_code, cmd_start);
        end
        idle(1);
        checks++;
        if (n_start != s0) begin
            errors++;
            $display("FAIL len_err_start got %0d exp 0", n_start - s0);
        end
        // length exactly at the limit is accepted
        send(8'hAA); send(8'h55); send(8'h07); send(8'h01); send(8'h00);
        checks++;
        if (cmd_start !== 1'b1 || cmd_length !== 16'h0100 || cmd_error !== 1'b0) begin
            errors++;
            $display("FAIL len_max got start=%b len=%h err=%b exp 1 0100 0",
                     cmd_start, cmd_length, cmd_error);
        end
        rst = 1'b1; idle(1); rst = 1'b0; idle(1);
        d0 = n_done;
        send(8'hAA); send(8'h55); send(8'hFF); send(8'h00); send(8'h00); send(8'hFF);
        checks++;
        if (cmd_done !== 1'b1) begin
            errors++;
            $display("FAIL len_err_recover got done=%b exp 1", cmd_done);
        end
        idle(1);
        checks++;
        if (n_done - d0 != 1) begin
            errors++;
            $display("FAIL len_err_recover_count got %0d exp 1", n_done - d0);
        end
    endtask

    task automatic test_timeout;
        int cyc, e0;
        bit seen;
        send(8'hAA); send(8'h55); send(8'h05); send(8'h00); send(8'h04); send(8'h50);
        cyc = 0; seen = 0;
        while (!seen && cyc < 4 * TMO) begin
            idle(1);
            cyc++;
            if (cmd_error === 1'b1) seen = 1;
        end
        checks++;
        if (!seen || cyc != TMO + 1 || err_code !== 2'b11) begin
            errors++;
            $display("FAIL timeout got seen=%0d cycle=%0d code=%b exp 1 %0d 11",
                     seen, cyc, err_code, TMO + 1);
        end
        idle(1);
        checks++;
        if (cmd_error !== 1'b0) begin
            errors++;
            $display("FAIL timeout_single_pulse got %b exp 0", cmd_error);
        end
        // byte lands on the cycle the counter reaches the limit: byte wins
        e0 = n_err;
        send(8'hAA); send(8'h55);
        idle(TMO);
        send(8'hFF); send(8'h00); send(8'h00); send(8'hFF);
        checks++;
        if (cmd_done !== 1'b1 || n_err != e0) begin
            errors++;
            $display("FAIL timeout_byte_wins got done=%b errs=%0d exp 1 0", cmd_done, n_err - e0);
        end
    endtask

    task automatic test_reset_mid;
        int e0, d0;
        e0 = n_err;
        send(8'hAA); send(8'h55); send(8'h05); send(8'h00); send(8'h04);
        send(8'h50); send(8'hAA);
        rst = 1'b1;
        #2;
        checks++;
        if ({cmd_type, cmd_length, cmd_start, payload_data, payload_valid,
             payload_index, cmd_done, cmd_error, err_code} !== '0) begin
            errors++;
            $display("FAIL reset_mid_outputs got type=%h len=%h d=%h i=%h exp all zero",
                     cmd_type, cmd_length, payload_data, payload_index);
        end
        idle(2);
        rst = 1'b0;
        idle(1);
        d0 = n_done;
        send(8'hAA); send(8'h55); send(8'h05); send(8'h00); send(8'h04);
        send(8'h50); send(8'hAA); send(8'h12); send(8'h34); send(8'h49);
        checks++;
        if (cmd_done !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_next got done=%b exp 1", cmd_done);
        end
        idle(2);
        checks++;
        if (n_err != e0 || n_done - d0 != 1) begin
            errors++;
            $display("FAIL reset_mid_counts got err=%0d done=%0d exp 0 1", n_err - e0, n_done - d0);
        end
    endtask

    task automatic test_back_to_back;
        int d0;
        d0 = n_done;
        send(8'hAA); send(8'h55); send(8'hFF); send(8'h00); send(8'h00); send(8'hFF);
        send(8'hAA); send(8'h55); send(8'h05); send(8'h00); send(8'h04);
        send(8'h50); send(8'hAA); send(8'h12); send(8'h34); send(8'h49);
        idle(2);
        checks++;
        if (n_done - d0 != 2) begin
            errors++;
            $display("FAIL back_to_back got %0d exp 2", n_done - d0);
        end
    endtask

    initial begin
        test_reset();
        test_heartbeat();
        test_i2c_write();
        test_gaps();
        test_resync();
        test_len_err();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
